// File: rtl/ws2812_decoder.sv
// ws2812_decoder: recovers bits from WS2812-style high-pulse widths on a single
// wire, packs them MSB-first into bytes and writes each byte to frame memory.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_WAIT_RESET | not armed; waiting for a full latch gap on the line
// S_IDLE       | armed; the next rising edge opens a frame
// S_HIGH       | line high; measuring the pulse width
// S_LOW        | line low between bits; watching for the latch gap
module ws2812_decoder #(
  parameter int INPUT_CLOCK_FREQ_MHZ = 50,
  parameter int MAX_LEDS             = 300,
  parameter int ADDRESS_WIDTH        = 12,
  parameter int BASE_ADDRESS         = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     din,
  output logic                     mem_we,
  output logic [7:0]               mem_wdata,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic                     frame_done,
  output logic                     frame_error,
  output logic                     overflow,
  output logic [15:0]              byte_count
);

  localparam int T_GLITCH  = INPUT_CLOCK_FREQ_MHZ * 100 / 1000;
  localparam int T_SPLIT   = INPUT_CLOCK_FREQ_MHZ * 600 / 1000;
  localparam int T_MAXHIGH = INPUT_CLOCK_FREQ_MHZ * 2;
  localparam int T_RESET   = INPUT_CLOCK_FREQ_MHZ * 50;
  localparam int CAP       = MAX_LEDS * 3;
  localparam int HW        = $clog2(T_MAXHIGH + 1);
  localparam int LW        = $clog2(T_RESET + 1);
  localparam int BW        = $clog2(CAP + 1);

  localparam logic [HW-1:0]            C_GLITCH  = HW'(T_GLITCH);
  localparam logic [HW-1:0]            C_SPLIT   = HW'(T_SPLIT);
  localparam logic [HW-1:0]            C_MAXHIGH = HW'(T_MAXHIGH);
  localparam logic [LW-1:0]            C_RESET   = LW'(T_RESET);
  localparam logic [BW-1:0]            C_CAP     = BW'(CAP);
  localparam logic [ADDRESS_WIDTH-1:0] C_BASE    = ADDRESS_WIDTH'(BASE_ADDRESS);

  typedef enum logic [1:0] {
    S_WAIT_RESET,
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2, r_prev;
  logic            w_rise, w_fall;
  logic [HW-1:0]   r_hcnt;
  logic [LW-1:0]   r_lcnt;
  logic [6:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic [BW-1:0]   r_byte_idx;
  logic            r_open;
  logic            w_start, w_bit_valid, w_bit, w_end_frame, w_stuck;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // Two-stage synchronizer plus the registered copy used for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Saturating high/low run-length counters; each clears when the line flips
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else begin
      if (!r_sync2)               r_hcnt <= '0;
      else if (r_hcnt != C_MAXHIGH) r_hcnt <= r_hcnt + 1'b1;
      if (r_sync2)                r_lcnt <= '0;
      else if (r_lcnt != C_RESET) r_lcnt <= r_lcnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_WAIT_RESET;
    else         r_state <= w_state_nxt;
  end

  // Next state and per-cycle decode events
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_bit_valid = 1'b0;
    w_end_frame = 1'b0;
    w_stuck     = 1'b0;
    w_bit       = (r_hcnt >= C_SPLIT);
    case (r_state)
      S_WAIT_RESET: begin
        if (r_lcnt == C_RESET) begin
          // a pulse landing exactly as the gap completes still opens a frame
          if (w_rise) begin
            w_start     = 1'b1;
            w_state_nxt = S_HIGH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (w_rise) begin
          w_start     = 1'b1;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_hcnt == C_MAXHIGH) begin
          w_stuck     = 1'b1;
          w_state_nxt = S_WAIT_RESET;
        end else if (w_fall) begin
          if (r_hcnt < C_GLITCH) begin
            w_state_nxt = r_open ? S_LOW : S_IDLE;
          end else begin
            w_bit_valid = 1'b1;
            w_state_nxt = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (r_lcnt == C_RESET) begin
          w_end_frame = 1'b1;
          if (w_rise) begin
            w_start     = 1'b1;
            w_state_nxt = S_HIGH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_rise) begin
          w_state_nxt = S_HIGH;
        end
      end
      default: w_state_nxt = S_WAIT_RESET;
    endcase
  end

  // Byte assembly, memory write port and frame status pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      mem_waddr   <= C_BASE;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      byte_count  <= '0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_byte_idx  <= '0;
      r_open      <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (w_end_frame) begin
        if (r_byte_idx != '0) begin
          frame_done <= 1'b1;
          byte_count <= 16'(r_byte_idx);
        end
        if (r_bitcnt != '0) frame_error <= 1'b1;
      end
      if (w_stuck) frame_error <= 1'b1;
      // start is evaluated after end-of-frame so a back-to-back frame
      // reports the old count before the index clears
      if (w_start) begin
        r_shift    <= '0;
        r_bitcnt   <= '0;
        r_byte_idx <= '0;
        r_open     <= 1'b0;
        overflow   <= 1'b0;
      end else if (w_bit_valid) begin
        r_open   <= 1'b1;
        r_shift  <= {r_shift[5:0], w_bit};
        r_bitcnt <= r_bitcnt + 1'b1;
        if (r_bitcnt == 3'd7) begin
          if (r_byte_idx < C_CAP) begin
            mem_we     <= 1'b1;
            mem_wdata  <= {r_shift, w_bit};
            mem_waddr  <= C_BASE + ADDRESS_WIDTH'(r_byte_idx);
            r_byte_idx <= r_byte_idx + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder (50 MHz timing, MAX_LEDS=2, base address 16).
module tb_ws2812_decoder;

  localparam int BASE = 16;

  logic        clk, resetn, din;
  logic        mem_we, frame_done, frame_error, overflow;
  logic [7:0]  mem_wdata;
  logic [11:0] mem_waddr;
  logic [15:0] byte_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_fall_cyc = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cnt, err_cnt, both_cnt, last_bc;

  ws2812_decoder #(
    .INPUT_CLOCK_FREQ_MHZ(50),
    .MAX_LEDS(2),
    .ADDRESS_WIDTH(12),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .din(din),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_waddr(mem_waddr),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .overflow(overflow),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // record every output event, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_waddr));
      wr_data.push_back(int'(mem_wdata));
      wr_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      last_bc = int'(byte_count);
    end
    if (frame_error) err_cnt++;
    if (frame_done && frame_error) both_cnt++;
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    err_cnt  = 0;
    both_cnt = 0;
    last_bc  = -1;
  endtask

  task automatic idle_low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // 62-cycle bit period: T0H 20, T1H 40
  task automatic send_bit(input logic b);
    din = 1'b1;
    repeat (b ? 40 : 20) @(negedge clk);
    din = 1'b0;
    last_fall_cyc = cyc;
    repeat (b ? 22 : 42) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    din    = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_we !== 1'b0)         begin failures++; $display("FAIL reset_we got=%0b exp=0", mem_we); end
    checks++; if (mem_wdata !== 8'h00)     begin failures++; $display("FAIL reset_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (mem_waddr !== 12'(BASE)) begin failures++; $display("FAIL reset_waddr got=%0d exp=%0d", mem_waddr, BASE); end
    checks++; if (frame_done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%0b exp=0", frame_done); end
    checks++; if (frame_error !== 1'b0)    begin failures++; $display("FAIL reset_error got=%0b exp=0", frame_error); end
    checks++; if (overflow !== 1'b0)       begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (byte_count !== 16'd0)    begin failures++; $display("FAIL reset_byte_count got=%0d exp=0", byte_count); end
    resetn = 1'b1;
  endtask

  task automatic test_not_armed();
    clear_mon();
    idle_low(100);
    send_byte(8'hA5);
    idle_low(3000);
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL unarmed_writes got=%0d exp=0", wr_addr.size()); end
    checks++; if (done_cnt != 0)       begin failures++; $display("FAIL unarmed_done got=%0d exp=0", done_cnt); end
    checks++; if (err_cnt != 0)        begin failures++; $display("FAIL unarmed_error got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_valid_frame();
    logic [7:0] exp_d [0:2];
    int fall0;
    exp_d[0] = 8'hA5; exp_d[1] = 8'h3C; exp_d[2] = 8'hFF;
    clear_mon();
    send_byte(8'hA5);
    fall0 = last_fall_cyc;
    send_byte(8'h3C);
    send_byte(8'hFF);
    idle_low(3000);
    checks++; if (wr_addr.size() != 3) begin failures++; $display("FAIL valid_nwrites got=%0d exp=3", wr_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_addr.size()) begin
        failures++; $display("FAIL valid_write%0d missing exp=%0d/%0h", i, BASE + i, exp_d[i]);
      end else if (wr_addr[i] != BASE + i || wr_data[i] != int'(exp_d[i])) begin
        failures++; $display("FAIL valid_write%0d got=%0d/%0h exp=%0d/%0h", i, wr_addr[i], wr_data[i], BASE + i, exp_d[i]);
      end
    end
    // din low sampled on edge 1, seen as a fall after edge 2, write registered on edge 3
    if (wr_cyc.size() > 0) begin
      checks++; if (wr_cyc[0] - fall0 != 3) begin failures++; $display("FAIL valid_latency got=%0d exp=3", wr_cyc[0] - fall0); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL valid_done got=%0d exp=1", done_cnt); end
    checks++; if (last_bc != 3)  begin failures++; $display("FAIL valid_byte_count got=%0d exp=3", last_bc); end
    checks++; if (err_cnt != 0)  begin failures++; $display("FAIL valid_error got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_glitch();
    logic [7:0] v;
    clear_mon();
    v = 8'h81;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        // '0' bit with a 3-cycle spike in its low phase
        din = 1'b1; repeat (20) @(negedge clk);
        din = 1'b0; repeat (10) @(negedge clk);
        din = 1'b1; repeat (3)  @(negedge clk);
        din = 1'b0; repeat (29) @(negedge clk);
      end else begin
        send_bit(v[i]);
      end
    end
    send_byte(8'h42);
    idle_low(3000);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL glitch_nwrites got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      checks++; if (wr_addr[0] != BASE || wr_data[0] != 'h81)
        begin failures++; $display("FAIL glitch_write0 got=%0d/%0h exp=%0d/81", wr_addr[0], wr_data[0], BASE); end
      checks++; if (wr_addr[1] != BASE + 1 || wr_data[1] != 'h42)
        begin failures++; $display("FAIL glitch_write1 got=%0d/%0h exp=%0d/42", wr_addr[1], wr_data[1], BASE + 1); end
    end
    checks++; if (last_bc != 2) begin failures++; $display("FAIL glitch_byte_count got=%0d exp=2", last_bc); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL glitch_error got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_stuck_high();
    clear_mon();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    din = 1'b1;
    repeat (120) @(negedge clk);
    idle_low(3000);
    checks++; if (err_cnt != 1)        begin failures++; $display("FAIL stuck_error got=%0d exp=1", err_cnt); end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL stuck_writes got=%0d exp=0", wr_addr.size()); end
    checks++; if (done_cnt != 0)       begin failures++; $display("FAIL stuck_done got=%0d exp=0", done_cnt); end
    clear_mon();
    send_byte(8'h5A);
    idle_low(3000);
    checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL after_stuck_nwrites got=%0d exp=1", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] != BASE || wr_data[0] != 'h5A)
        begin failures++; $display("FAIL after_stuck_write got=%0d/%0h exp=%0d/5a", wr_addr[0], wr_data[0], BASE); end
    end
    checks++; if (done_cnt != 1 || last_bc != 1) begin failures++; $display("FAIL after_stuck_done got=%0d/%0d exp=1/1", done_cnt, last_bc); end
  endtask

  task automatic test_overflow();
    clear_mon();
    for (int b = 1; b <= 7; b++) send_byte(8'(b));
    idle_low(3000);
    checks++; if (wr_addr.size() != 6) begin failures++; $display("FAIL ovf_nwrites got=%0d exp=6", wr_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= wr_addr.size()) begin
        failures++; $display("FAIL ovf_write%0d missing", i);
      end else if (wr_addr[i] != BASE + i || wr_data[i] != i + 1) begin
        failures++; $display("FAIL ovf_write%0d got=%0d/%0h exp=%0d/%0h", i, wr_addr[i], wr_data[i], BASE + i, i + 1);
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (done_cnt != 1 || last_bc != 6) begin failures++; $display("FAIL ovf_done got=%0d/%0d exp=1/6", done_cnt, last_bc); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL ovf_error got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_partial();
    clear_mon();
    send_byte(8'hC3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle_low(3000);
    checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL partial_nwrites got=%0d exp=1", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] != BASE || wr_data[0] != 'hC3)
        begin failures++; $display("FAIL partial_write got=%0d/%0h exp=%0d/c3", wr_addr[0], wr_data[0], BASE); end
    end
    checks++; if (done_cnt != 1 || err_cnt != 1) begin failures++; $display("FAIL partial_pulses done=%0d err=%0d exp=1/1", done_cnt, err_cnt); end
    checks++; if (both_cnt != 1) begin failures++; $display("FAIL partial_same_cycle got=%0d exp=1", both_cnt); end
    checks++; if (last_bc != 1)  begin failures++; $display("FAIL partial_byte_count got=%0d exp=1", last_bc); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL partial_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_reset_mid_byte();
    clear_mon();
    for (int b = 1; b <= 7; b++) send_byte(8'(b));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL midrst_pre_overflow got=%0b exp=1", overflow); end
    checks++; if (mem_waddr !== 12'(BASE + 5)) begin failures++; $display("FAIL midrst_pre_waddr got=%0d exp=%0d", mem_waddr, BASE + 5); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0)         begin failures++; $display("FAIL midrst_we got=%0b exp=0", mem_we); end
    checks++; if (mem_wdata !== 8'h00)     begin failures++; $display("FAIL midrst_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (mem_waddr !== 12'(BASE)) begin failures++; $display("FAIL midrst_waddr got=%0d exp=%0d", mem_waddr, BASE); end
    checks++; if (frame_done !== 1'b0 || frame_error !== 1'b0)
      begin failures++; $display("FAIL midrst_pulses got=%0b%0b exp=00", frame_done, frame_error); end
    checks++; if (overflow !== 1'b0)       begin failures++; $display("FAIL midrst_overflow got=%0b exp=0", overflow); end
    checks++; if (byte_count !== 16'd0)    begin failures++; $display("FAIL midrst_byte_count got=%0d exp=0", byte_count); end
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    clear_mon();
    idle_low(50);
    send_byte(8'h77);
    idle_low(1000);
    checks++; if (wr_addr.size() != 0 || done_cnt != 0)
      begin failures++; $display("FAIL midrst_unarmed got=%0d writes %0d done exp=0/0", wr_addr.size(), done_cnt); end
    idle_low(2000);
    send_byte(8'h24);
    idle_low(3000);
    checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL midrst_rearm_nwrites got=%0d exp=1", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] != BASE || wr_data[0] != 'h24)
        begin failures++; $display("FAIL midrst_rearm_write got=%0d/%0h exp=%0d/24", wr_addr[0], wr_data[0], BASE); end
    end
  endtask

  initial begin
    resetn = 1'b0;
    din    = 1'b0;
    clear_mon();
    test_reset();
    test_not_armed();
    test_valid_frame();
    test_glitch();
    test_stuck_high();
    test_overflow();
    test_partial();
    test_reset_mid_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
